program_loader: RTL

// Write-side companion to the instruction store: accepts a program image as a byte stream
// (valid/ready) and writes it word by word into instruction memory through a write port.

---
 rtl/program_loader_pkg.sv | 11 +
 rtl/program_loader.sv | 69 ++++++
 2 files changed

// File: rtl/program_loader_pkg.sv
// program_loader_pkg: byte width and FSM state encodings shared by the loader
package program_loader_pkg;
  localparam int BYTE_W = 8;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
endpackage

// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed big-endian byte stream into instruction memory
module program_loader
  import program_loader_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WORD_W-1:0] mem_wr_data,
  output logic [15:0]       num_instructions,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);
  logic [2:0]        state;
  logic [BYTE_W-1:0] hi_byte;
  logic [ADDR_W:0]   wr_ptr;
  logic [15:0]       pair;
  logic [15:0]       next_ptr;
  assign in_ready   = state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO};
  assign busy       = in_ready;
  assign load_done  = state == S_DONE;
  assign load_error = state == S_ERROR;
  assign pair       = {hi_byte, in_data};
  assign next_ptr   = 16'(wr_ptr) + 16'd1;
  always_ff @(posedge clk) begin
    mem_wr_en <= 1'b0;
    if (reset) begin
      state            <= S_IDLE;
      hi_byte          <= '0;
      wr_ptr           <= '0;
      num_instructions <= '0;
      mem_wr_addr      <= '0;
      mem_wr_data      <= '0;
    end else if (!busy) begin
      if (start) begin
        state            <= S_LEN_HI;
        wr_ptr           <= '0;
        num_instructions <= '0;
      end
    end else if (in_valid) begin
      case (state)
        S_LEN_HI, S_DATA_HI: begin
          hi_byte <= in_data;
          state   <= state + 3'd1;
        end
        S_LEN_LO: begin
          state <= pair == 16'd0 ? S_DONE : pair > 16'(MEM_DEPTH) ? S_ERROR : S_DATA_HI;
          if (pair != 16'd0 && pair <= 16'(MEM_DEPTH)) num_instructions <= pair;
        end
        default: begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= wr_ptr[ADDR_W-1:0];
          mem_wr_data <= WORD_W'(pair);
          wr_ptr      <= next_ptr[ADDR_W:0];
          state       <= next_ptr == num_instructions ? S_DONE : S_DATA_HI;
        end
      endcase
    end
  end
endmodule
